// File: rtl/string_seq_pkg.sv
// Shared types and constants for the string byte sequencer.
// FSM encoding, character width and default string length.
package string_seq_pkg;

   localparam int CHAR_W        = 8;
   localparam int MAX_CHARS_DEF = 11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } seq_state_t;

endpackage

// File: rtl/string_char_select.sv
// Combinational character picker for a packed string.
// Character 0 sits in the most significant byte; out-of-range yields 0.
module string_char_select
   import string_seq_pkg::*;
#(
   parameter int MAX_CHARS = MAX_CHARS_DEF,
   parameter int IDX_W     = $clog2(MAX_CHARS+1)
) (
   input  logic [MAX_CHARS*CHAR_W-1:0] str,
   input  logic [IDX_W-1:0]            idx,
   output logic [CHAR_W-1:0]           ch
);

   // one-hot compare of idx against every legal position
   always_comb begin
      ch = '0;
      for (int i = 0; i < MAX_CHARS; i++) begin
         if (idx == IDX_W'(i)) begin
            ch = str[(MAX_CHARS-1-i)*CHAR_W +: CHAR_W];
         end
      end
   end

endmodule

// File: rtl/string_byte_sequencer.sv
// Emits a substring of a captured packed string one byte per
// valid/ready handshake, with done/err status pulses.
module string_byte_sequencer
   import string_seq_pkg::*;
#(
   parameter int MAX_CHARS = MAX_CHARS_DEF,
   parameter int CNT_W     = $clog2(MAX_CHARS+1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [MAX_CHARS*CHAR_W-1:0] str_in,
   input  logic [CNT_W-1:0]            start_idx,
   input  logic [CNT_W-1:0]            len,
   input  logic                        out_ready,
   output logic                        out_valid,
   output logic [CHAR_W-1:0]           out_byte,
   output logic                        out_last,
   output logic                        busy,
   output logic                        done,
   output logic                        err
);

   localparam int STR_W = MAX_CHARS*CHAR_W;
   localparam logic [CNT_W:0] MAX_EXT = (CNT_W+1)'(MAX_CHARS);

   seq_state_t       state;
   logic [STR_W-1:0] str_q;
   logic [CNT_W-1:0] idx_q;
   logic [CNT_W-1:0] rem_q;
   logic [CNT_W:0]   end_sum;
   logic             req_bad;
   logic             hs;
   logic [STR_W-1:0] sel_str;
   logic [CNT_W-1:0] sel_idx;
   logic [CHAR_W-1:0] sel_ch;

   // one extra bit so start_idx+len cannot wrap
   assign end_sum = {1'b0, start_idx} + {1'b0, len};
   assign req_bad = (len == '0) || (end_sum > MAX_EXT);
   assign hs      = out_valid && out_ready;

   // first byte comes from the live request, later ones from the copy
   always_comb begin
      sel_str = str_q;
      sel_idx = idx_q + CNT_W'(1);
      if (state == IDLE) begin
         sel_str = str_in;
         sel_idx = start_idx;
      end
   end

   string_char_select #(
      .MAX_CHARS (MAX_CHARS),
      .IDX_W     (CNT_W)
   ) u_sel (
      .str (sel_str),
      .idx (sel_idx),
      .ch  (sel_ch)
   );

   // control FSM with registered outputs; rem_q = bytes left after current
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         str_q     <= '0;
         idx_q     <= '0;
         rem_q     <= '0;
         out_valid <= 1'b0;
         out_byte  <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  str_q <= str_in;
                  idx_q <= start_idx;
                  rem_q <= len - CNT_W'(1);
                  if (req_bad) begin
                     err <= 1'b1;
                  end else begin
                     state     <= SEND;
                     busy      <= 1'b1;
                     out_valid <= 1'b1;
                     out_byte  <= sel_ch;
                     out_last  <= (len == CNT_W'(1));
                  end
               end
            end
            SEND: begin
               if (hs) begin
                  if (out_last) begin
                     state     <= DONE;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     out_byte  <= '0;
                     done      <= 1'b1;
                  end else begin
                     idx_q    <= idx_q + CNT_W'(1);
                     out_byte <= sel_ch;
                     rem_q    <= rem_q - CNT_W'(1);
                     out_last <= (rem_q == CNT_W'(1));
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_string_byte_sequencer.sv
// Directed bench for string_byte_sequencer.
// Expected bytes come from a hand-written ASCII table.
module tb_string_byte_sequencer;

   localparam int MC = 11;
   localparam int CW = 4;
   localparam logic [87:0] HW   = "hello world";
   localparam logic [87:0] JUNK = {11{8'h58}};

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [MC*8-1:0] str_in = '0;
   logic [CW-1:0] start_idx = '0;
   logic [CW-1:0] len = '0;
   logic          out_ready = 1'b0;
   logic          out_valid;
   logic [7:0]    out_byte;
   logic          out_last;
   logic          busy;
   logic          done;
   logic          err;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] exp_hw [11] = '{
      8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
      8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64
   };

   string_byte_sequencer #(
      .MAX_CHARS (MC),
      .CNT_W     (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .str_in    (str_in),
      .start_idx (start_idx),
      .len       (len),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_byte  (out_byte),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic xfer(input int si, input int ln,
                       input bit stall, input bit restart);
      int k;
      int cyc;
      str_in    = HW;
      start_idx = CW'(si);
      len       = CW'(ln);
      start     = 1'b1;
      out_ready = 1'b1;
      step();
      start  = 1'b0;
      str_in = JUNK;
      chk("lat_busy", 32'(busy), 1);
      k   = 0;
      cyc = 0;
      while (k < ln && cyc < 60) begin
         out_ready = stall ? (cyc % 3 == 0) : 1'b1;
         if (restart && cyc == 2) begin
            start     = 1'b1;
            start_idx = CW'(0);
            len       = CW'(3);
         end else begin
            start = 1'b0;
         end
         chk("valid", 32'(out_valid), 1);
         chk("byte", 32'(out_byte), 32'(exp_hw[si+k]));
         chk("last", 32'(out_last), 32'(k == ln-1));
         step();
         if (out_ready) k++;
         cyc++;
      end
      start     = 1'b0;
      out_ready = 1'b1;
      chk("hs_count", k, ln);
      if (!stall) chk("cycles", cyc, ln);
      chk("done", 32'(done), 1);
      chk("done_busy", 32'(busy), 1);
      chk("done_valid", 32'(out_valid), 0);
      step();
      chk("idle_done", 32'(done), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_valid", 32'(out_valid), 0);
      step();
      chk("no_queue_valid", 32'(out_valid), 0);
      chk("no_queue_done", 32'(done), 0);
   endtask

   task automatic bad_req(input int si, input int ln);
      str_in    = HW;
      start_idx = CW'(si);
      len       = CW'(ln);
      start     = 1'b1;
      step();
      start = 1'b0;
      chk("err_pulse", 32'(err), 1);
      chk("err_valid", 32'(out_valid), 0);
      chk("err_busy", 32'(busy), 0);
      chk("err_done", 32'(done), 0);
      step();
      chk("err_clear", 32'(err), 0);
      chk("err_valid2", 32'(out_valid), 0);
      chk("err_busy2", 32'(busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      step();
      step();
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_byte", 32'(out_byte), 0);
      chk("rst_last", 32'(out_last), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      rst = 1'b0;
      step();
      chk("idle_valid0", 32'(out_valid), 0);

      xfer(0, 11, 1'b0, 1'b0);
      xfer(6, 5, 1'b1, 1'b0);
      xfer(10, 1, 1'b0, 1'b0);
      bad_req(8, 4);
      bad_req(0, 0);
      bad_req(15, 15);
      xfer(0, 11, 1'b0, 1'b1);

      str_in    = HW;
      start_idx = CW'(0);
      len       = CW'(11);
      start     = 1'b1;
      out_ready = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("pre_rst_byte", 32'(out_byte), 32'(exp_hw[i]));
         step();
      end
      chk("pre_rst_b3", 32'(out_byte), 32'(exp_hw[3]));
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", 32'(out_valid), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_byte", 32'(out_byte), 0);
      chk("arst_last", 32'(out_last), 0);
      step();
      chk("arst_done", 32'(done), 0);
      step();
      chk("arst_done2", 32'(done), 0);
      rst = 1'b0;
      xfer(4, 2, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
